uart_rx_fifo: RTL

- Receive buffer directly downstream of the UART receiver.
- Captures each byte the receiver flags as valid into a power-of-two circular FIFO and presents it to the CPU bus side with first-word-fall-through semantics.
- Provides full/empty/count status, a level-based interrupt request, a sticky overflow flag and a synchronous flush.

---
 rtl/uart_rx_fifo.sv | 87 ++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: edge-detected capture,
// first-word-fall-through read port, occupancy status, level IRQ and sticky overflow.
module uart_rx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned IRQ_LEVEL = 1
) (
  input  logic              I_clk,
  input  logic              I_reset_n,
  input  logic              I_rx_valid,
  input  logic [7:0]        I_rx_data,
  input  logic              I_read,
  input  logic              I_flush,
  input  logic              I_clear_overflow,
  output logic [7:0]        O_data,
  output logic              O_empty,
  output logic              O_full,
  output logic [ADDR_W:0]   O_count,
  output logic              O_overflow,
  output logic              O_irq
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] IRQ_CNT  = CNT_W'(IRQ_LEVEL);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              rx_valid_q;
  logic              overflow;

  logic wr_event_c;
  logic rd_ok_c;
  logic wr_ok_c;
  logic ovf_set_c;

  // A held-high valid writes once; a flush discards whatever else happens this cycle.
  always_comb begin
    wr_event_c = I_rx_valid & ~rx_valid_q;
    rd_ok_c    = I_read & (count != '0) & ~I_flush;
    wr_ok_c    = wr_event_c & ~I_flush & ((count != FULL_CNT) | rd_ok_c);
    ovf_set_c  = wr_event_c & ~I_flush & ~wr_ok_c;
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_valid_q <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rx_valid_q <= I_rx_valid;
      if (I_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_ok_c) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (rd_ok_c) rd_ptr <= rd_ptr + ADDR_W'(1);
        case ({wr_ok_c, rd_ok_c})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
      // Set beats clear when both land in the same cycle.
      if (ovf_set_c)             overflow <= 1'b1;
      else if (I_clear_overflow) overflow <= 1'b0;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge I_clk) begin
    if (wr_ok_c) mem[wr_ptr] <= I_rx_data;
  end

  assign O_data     = mem[rd_ptr];
  assign O_count    = count;
  assign O_empty    = (count == '0);
  assign O_full     = (count == FULL_CNT);
  assign O_irq      = (count >= IRQ_CNT);
  assign O_overflow = overflow;

endmodule
